// File: rtl/signal_source_pkg.sv
// rtl/signal_source_pkg.sv - shared states and pattern codes for signal_source
package signal_source_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_COUNT = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_WALK  = 2'd3;

endpackage

// File: rtl/source_next_word.sv
// rtl/source_next_word.sv - combinational successor of a pattern word
module source_next_word
    import signal_source_pkg::*;
#(
    parameter int                 WIDTH = 32,
    parameter logic [WIDTH-1:0]   TAPS  = 32'h8020_0003
) (
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_word,
    output logic [WIDTH-1:0] o_next
);

    // Pick the successor word for the active pattern
    always_comb begin
        o_next = i_word;
        case (i_mode)
            MODE_CONST: o_next = i_word;
            MODE_COUNT: o_next = i_word + WIDTH'(1);
            MODE_LFSR:  o_next = {i_word[WIDTH-2:0], ^(i_word & TAPS)};
            MODE_WALK:  o_next = {i_word[WIDTH-2:0], i_word[WIDTH-1]};
            default:    o_next = i_word;
        endcase
    end

endmodule

// File: rtl/signal_source.sv
// rtl/signal_source.sv - burst word generator with valid/ready output
module signal_source
    import signal_source_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = 32'h8020_0003
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [15:0]      count,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_mode;
    logic [15:0]      r_remaining;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_next_word;
    logic [WIDTH-1:0] w_first_word;
    logic             w_accept;
    logic             w_xfer;

    // A zero seed would lock LFSR and WALK at zero, so those start from 1
    always_comb begin
        w_first_word = seed;
        if ((mode == MODE_LFSR || mode == MODE_WALK) && seed == '0)
            w_first_word = WIDTH'(1);
    end

    assign w_accept = (r_state == IDLE) && start;
    assign w_xfer   = (r_state == RUN) && ready;

    source_next_word #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .i_mode (r_mode),
        .i_word (r_data),
        .o_next (w_next_word)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic: the transfer that consumes the last word ends the burst
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start)
                    w_state_next = (count != 16'd0) ? RUN : DONE;
            end
            RUN: begin
                if (ready && r_remaining == 16'd1)
                    w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Burst parameters are latched on start; the word advances only on a transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode      <= MODE_CONST;
            r_remaining <= 16'd0;
            r_data      <= '0;
        end else if (w_accept) begin
            r_mode      <= mode;
            r_remaining <= count;
            r_data      <= w_first_word;
        end else if (w_xfer) begin
            r_remaining <= r_remaining - 16'd1;
            r_data      <= w_next_word;
        end
    end

    assign data_out = r_data;
    assign valid    = (r_state == RUN);
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);

endmodule

// File: tb/tb_signal_source.sv
// tb/tb_signal_source.sv - directed self-checking bench for signal_source
module tb_signal_source;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] count = 16'd0;
    logic [31:0] seed = 32'd0;
    logic [31:0] data_out;
    logic        valid;
    logic        ready = 1'b1;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_mis = 0;

    signal_source #(
        .WIDTH (32),
        .TAPS  (32'h8020_0003)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .mode     (mode),
        .count    (count),
        .seed     (seed),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Pulse start for one cycle; returns at the falling edge of the first burst cycle
    task automatic start_burst(input logic [1:0] m, input logic [15:0] c, input logic [31:0] s);
        @(negedge clk);
        mode  = m;
        count = c;
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({valid, busy, done} !== 3'b000 || data_out !== 32'd0) begin
            n_mis++;
            $display("FAIL reset_outputs: valid=%b busy=%b done=%b data=%h required 0 0 0 00000000",
                     valid, busy, done, data_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({valid, busy, done} !== 3'b000) begin
                n_mis++;
                $display("FAIL idle_after_reset: valid=%b busy=%b done=%b required 0 0 0",
                         valid, busy, done);
            end
        end
    endtask

    task automatic test_count();
        logic [31:0] exp_w [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        ready = 1'b1;
        start_burst(2'd1, 16'd4, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (valid !== 1'b1 || busy !== 1'b1 || data_out !== exp_w[i]) begin
                n_mis++;
                $display("FAIL count_word%0d: valid=%b busy=%b data=%h required 1 1 %h",
                         i, valid, busy, data_out, exp_w[i]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (valid !== 1'b0 || done !== 1'b1) begin
            n_mis++;
            $display("FAIL count_done: valid=%b done=%b required 0 1", valid, done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL count_done_width: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_lfsr();
        logic [31:0] exp_w [4] = '{32'h1, 32'h3, 32'h6, 32'hD};
        start_burst(2'd2, 16'd4, 32'd0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (valid !== 1'b1 || data_out !== exp_w[i]) begin
                n_mis++;
                $display("FAIL lfsr_word%0d: valid=%b data=%h required 1 %h",
                         i, valid, data_out, exp_w[i]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_mis++;
            $display("FAIL lfsr_done: done=%b required 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_walk();
        logic [31:0] exp_w [3] = '{32'h8000_0000, 32'h1, 32'h2};
        start_burst(2'd3, 16'd3, 32'h8000_0000);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (valid !== 1'b1 || data_out !== exp_w[i]) begin
                n_mis++;
                $display("FAIL walk_word%0d: valid=%b data=%h required 1 %h",
                         i, valid, data_out, exp_w[i]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1 || valid !== 1'b0) begin
            n_mis++;
            $display("FAIL walk_done: done=%b valid=%b required 1 0", done, valid);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int xfers = 0;
        start_burst(2'd0, 16'd3, 32'h5A);
        for (int c = 1; c <= 6; c++) begin
            ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            n_cmp++;
            if (valid !== 1'b1 || done !== 1'b0 || data_out !== 32'h5A) begin
                n_mis++;
                $display("FAIL bp_cycle%0d: valid=%b done=%b data=%h required 1 0 0000005a",
                         c, valid, done, data_out);
            end
            if (valid === 1'b1 && ready === 1'b1) xfers++;
            @(negedge clk);
        end
        ready = 1'b1;
        n_cmp++;
        if (xfers !== 3) begin
            n_mis++;
            $display("FAIL bp_transfers: got %0d required 3", xfers);
        end
        n_cmp++;
        if (done !== 1'b1 || valid !== 1'b0) begin
            n_mis++;
            $display("FAIL bp_done: done=%b valid=%b required 1 0", done, valid);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        start_burst(2'd1, 16'd0, 32'h1234);
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
            n_mis++;
            $display("FAIL zero_count_done: valid=%b busy=%b done=%b required 0 0 1",
                     valid, busy, done);
        end
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0 || done !== 1'b0) begin
            n_mis++;
            $display("FAIL zero_count_idle: valid=%b done=%b required 0 0", valid, done);
        end
    endtask

    task automatic test_start_in_run();
        logic [31:0] exp_w [3] = '{32'h10, 32'h11, 32'h12};
        start_burst(2'd1, 16'd3, 32'h10);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (valid !== 1'b1 || data_out !== exp_w[i]) begin
                n_mis++;
                $display("FAIL run_start_word%0d: valid=%b data=%h required 1 %h",
                         i, valid, data_out, exp_w[i]);
            end
            if (i == 0) begin
                mode  = 2'd0;
                count = 16'd8;
                seed  = 32'h77;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1 || valid !== 1'b0) begin
            n_mis++;
            $display("FAIL run_start_done: done=%b valid=%b required 1 0", done, valid);
        end
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL run_start_idle: valid=%b busy=%b required 0 0", valid, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit saw_done = 1'b0;
        start_burst(2'd1, 16'd10, 32'h100);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (valid !== 1'b1 || data_out !== 32'h100 + i) begin
                n_mis++;
                $display("FAIL mid_word%0d: valid=%b data=%h required 1 %h",
                         i, valid, data_out, 32'h100 + i);
            end
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({valid, busy, done} !== 3'b000 || data_out !== 32'd0) begin
            n_mis++;
            $display("FAIL mid_reset_async: valid=%b busy=%b done=%b data=%h required 0 0 0 00000000",
                     valid, busy, done, data_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1 || valid === 1'b1) saw_done = 1'b1;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (done === 1'b1 || valid === 1'b1) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_mis++;
            $display("FAIL mid_no_done: activity seen=%b required 0", saw_done);
        end
        start_burst(2'd1, 16'd10, 32'h200);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (valid !== 1'b1 || data_out !== 32'h200 + i) begin
                n_mis++;
                $display("FAIL fresh_word%0d: valid=%b data=%h required 1 %h",
                         i, valid, data_out, 32'h200 + i);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1 || valid !== 1'b0) begin
            n_mis++;
            $display("FAIL fresh_done: done=%b valid=%b required 1 0", done, valid);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_count();
        test_lfsr();
        test_walk();
        test_backpressure();
        test_zero_count();
        test_start_in_run();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
